// File: rtl/screen_buffer.sv
// Pixel frame buffer for the VGA display stage.
// Snoops CPU writes into the screen window and serves a 1-cycle-latency
// read port to the display stage. A clear engine zeroes the buffer after
// reset or on clear_req. CPU writes take priority over the sweep.
// Optional build macro: SCREEN_BUFFER_BYPASS_EN (write-first read path).
module screen_buffer #(
   parameter logic [15:0] BASE_ADDR = 16'h0200,
   parameter int          DEPTH     = 1024,
   parameter int          DATA_W    = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [15:0]       cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   input  logic              cpu_we,
   input  logic [15:0]       disp_addr,
   output logic [DATA_W-1:0] disp_data,
   input  logic              clear_req,
   output logic              busy
);

   localparam int               PTR_W    = $clog2(DEPTH);
   localparam logic [31:0]      DEPTH_U  = 32'(DEPTH);
   localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(DEPTH - 1);

   typedef enum logic {ST_CLEAR, ST_IDLE} state_t;

   state_t           state_q, state_d;
   logic [PTR_W-1:0] clr_ptr_q, clr_ptr_d;
   logic             was_clear_q;
   logic             rd_ok_q;
   logic [DATA_W-1:0] rd_data_q;

   logic [15:0]       cpu_idx, disp_idx;
   logic              cpu_hit, disp_hit, cpu_acc;
   logic              mem_we;
   logic [PTR_W-1:0]  mem_waddr;
   logic [DATA_W-1:0] mem_wdata;

   logic [DATA_W-1:0] mem [DEPTH];

   // Shared window decode: wrap-around subtraction makes below-base addresses huge
   assign cpu_idx  = cpu_addr - BASE_ADDR;
   assign disp_idx = disp_addr - BASE_ADDR;
   assign cpu_hit  = {16'd0, cpu_idx} < DEPTH_U;
   assign disp_hit = {16'd0, disp_idx} < DEPTH_U;
   assign cpu_acc  = cpu_we & cpu_hit;

   assign busy = (state_q == ST_CLEAR);

   // Single write port: an accepted CPU write wins, otherwise the sweep writes zero
   always_comb begin
      mem_we    = 1'b0;
      mem_waddr = '0;
      mem_wdata = '0;
      if (cpu_acc) begin
         mem_we    = 1'b1;
         mem_waddr = cpu_idx[PTR_W-1:0];
         mem_wdata = cpu_wdata;
      end else if (state_q == ST_CLEAR) begin
         mem_we    = 1'b1;
         mem_waddr = clr_ptr_q;
      end
   end

   // Clear engine next-state: sweep stalls on CPU writes, clear_req restarts it
   always_comb begin
      state_d   = state_q;
      clr_ptr_d = clr_ptr_q;
      case (state_q)
         ST_CLEAR: begin
            if (clear_req) begin
               clr_ptr_d = '0;
            end else if (!cpu_acc) begin
               if (clr_ptr_q == LAST_IDX) begin
                  state_d   = ST_IDLE;
                  clr_ptr_d = '0;
               end else begin
                  clr_ptr_d = clr_ptr_q + PTR_W'(1);
               end
            end
         end
         ST_IDLE: begin
            if (clear_req) begin
               state_d   = ST_CLEAR;
               clr_ptr_d = '0;
            end
         end
         default: begin
            state_d   = ST_CLEAR;
            clr_ptr_d = '0;
         end
      endcase
   end

   // Control registers: reset lands in CLEAR so the buffer is always swept
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_CLEAR;
         clr_ptr_q   <= '0;
         was_clear_q <= 1'b1;
         rd_ok_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         clr_ptr_q   <= clr_ptr_d;
         was_clear_q <= (state_q == ST_CLEAR);
         rd_ok_q     <= disp_hit && (state_q != ST_CLEAR) && !was_clear_q;
      end
   end

   // Pixel storage write port, no reset on the array
   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem[mem_waddr] <= mem_wdata;
      end
   end

`ifdef SCREEN_BUFFER_BYPASS_EN
   logic fwd;
   assign fwd = cpu_acc && (cpu_idx == disp_idx);

   // Synchronous read with write-first forwarding of a same-entry CPU write
   always_ff @(posedge clk) begin
      rd_data_q <= fwd ? cpu_wdata : mem[disp_idx[PTR_W-1:0]];
   end
`else
   // Synchronous read, read-first against a same-cycle write
   always_ff @(posedge clk) begin
      rd_data_q <= mem[disp_idx[PTR_W-1:0]];
   end
`endif

   // Out-of-window reads and reads during or just after a sweep return zero
   assign disp_data = rd_ok_q ? rd_data_q : '0;

endmodule

// File: tb/tb_screen_buffer.sv
// Self-checking bench for screen_buffer: directed vectors, read expectations
// queued at issue time and compared by a separate monitor process.
module tb_screen_buffer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [15:0] cpu_addr;
   logic [7:0]  cpu_wdata;
   logic        cpu_we;
   logic [15:0] disp_addr;
   logic [7:0]  disp_data;
   logic        clear_req;
   logic        busy;

   logic        rd_issue;
   int          n_checks = 0;
   int          n_fail   = 0;
   int          busy_cnt = 0;
   int          busy_start;

   typedef struct {
      string      name;
      logic [7:0] exp;
   } exp_t;

   exp_t sb_q[$];
   exp_t mon_e;

   screen_buffer dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .cpu_addr  (cpu_addr),
      .cpu_wdata (cpu_wdata),
      .cpu_we    (cpu_we),
      .disp_addr (disp_addr),
      .disp_data (disp_data),
      .clear_req (clear_req),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Monitor: a read issued before this edge presents its data just after it
   always @(posedge clk) begin
      if (rd_issue) begin
         #1;
         if (sb_q.size() == 0) begin
            check("sb_underflow", 32'd1, 32'd0);
         end else begin
            mon_e = sb_q.pop_front();
            check(mon_e.name, 32'(disp_data), 32'(mon_e.exp));
         end
      end
   end

   // Busy-cycle counter sampled mid-cycle
   always @(negedge clk) begin
      if (busy === 1'b1) busy_cnt++;
   end

   task automatic cyc(input logic we, input logic [15:0] wa, input logic [7:0] wd,
                      input logic rd, input logic [15:0] ra, input logic [7:0] ex,
                      input string nm);
      @(negedge clk);
      cpu_we    = we;
      cpu_addr  = wa;
      cpu_wdata = wd;
      rd_issue  = rd;
      disp_addr = ra;
      clear_req = 1'b0;
      if (rd) sb_q.push_back('{nm, ex});
   endtask

   task automatic wr(input logic [15:0] a, input logic [7:0] d);
      cyc(1'b1, a, d, 1'b0, 16'h0000, 8'h00, "");
   endtask

   task automatic rd(input logic [15:0] a, input logic [7:0] e, input string nm);
      cyc(1'b0, 16'h0000, 8'h00, 1'b1, a, e, nm);
   endtask

   task automatic idle();
      cyc(1'b0, 16'h0000, 8'h00, 1'b0, 16'h0000, 8'h00, "");
   endtask

   task automatic pulse_clear();
      @(negedge clk);
      cpu_we     = 1'b0;
      rd_issue   = 1'b0;
      clear_req  = 1'b1;
      busy_start = busy_cnt;
   endtask

   task automatic wait_idle(input string nm, input int exp_cycles);
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         if (busy === 1'b0) break;
      end
      check({nm, "_timeout"}, 32'(busy), 32'd0);
      check(nm, 32'(busy_cnt - busy_start), 32'(exp_cycles));
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_n     = 1'b0;
      cpu_addr  = '0;
      cpu_wdata = '0;
      cpu_we    = 1'b0;
      disp_addr = '0;
      clear_req = 1'b0;
      rd_issue  = 1'b0;
      busy_start = 0;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check("reset_busy", 32'(busy), 32'd1);
      check("reset_disp_data", 32'(disp_data), 32'd0);

      // Release reset mid-cycle and time the power-on sweep
      @(posedge clk);
      #3;
      rst_n      = 1'b1;
      busy_start = busy_cnt;
      wait_idle("reset_sweep_cycles", 1024);

      rd(16'h0200, 8'h00, "post_reset_0200");
      rd(16'h03FF, 8'h00, "post_reset_03FF");
      rd(16'h05FF, 8'h00, "post_reset_05FF");

      // Window edges
      wr(16'h0200, 8'h05);
      wr(16'h05FF, 8'h03);
      rd(16'h0200, 8'h05, "wr_first_0200");
      rd(16'h05FF, 8'h03, "wr_last_05FF");

      // Out-of-window writes must not alias into the buffer
      wr(16'h01FF, 8'hFF);
      wr(16'h0600, 8'hFF);
      rd(16'h01FF, 8'h00, "oow_read_01FF");
      rd(16'h0600, 8'h00, "oow_read_0600");
      rd(16'h0200, 8'h05, "oow_keep_0200");
      rd(16'h05FF, 8'h03, "oow_keep_05FF");

      wr(16'h03FF, 8'hA5);
      rd(16'h03FF, 8'hA5, "mid_03FF");

      // Read during write to the same entry
      wr(16'h0300, 8'h02);
`ifdef SCREEN_BUFFER_BYPASS_EN
      cyc(1'b1, 16'h0300, 8'h07, 1'b1, 16'h0300, 8'h07, "rdw_same_0300");
`else
      cyc(1'b1, 16'h0300, 8'h07, 1'b1, 16'h0300, 8'h02, "rdw_same_0300");
`endif
      rd(16'h0300, 8'h07, "rdw_after_0300");

      // Clear request with a 10-cycle write burst stalling the sweep
      pulse_clear();
      for (int i = 0; i < 10; i++) begin
         wr(16'h0250 + 16'(i), 8'h11);
         if (i == 0) check("clear_busy_next", 32'(busy), 32'd1);
      end
      idle();
      wait_idle("clear_stall_cycles", 1034);

      rd(16'h0200, 8'h00, "cleared_0200");
      rd(16'h0250, 8'h00, "cleared_0250");
      rd(16'h0259, 8'h00, "cleared_0259");
      rd(16'h0300, 8'h00, "cleared_0300");
      rd(16'h03FF, 8'h00, "cleared_03FF");
      rd(16'h05FF, 8'h00, "cleared_05FF");
      wr(16'h0400, 8'h3C);
      wr(16'h0210, 8'h5A);
      rd(16'h0400, 8'h3C, "after_clear_0400");
      rd(16'h0210, 8'h5A, "after_clear_0210");

      // Reset in the middle of a sweep at clr_ptr = 500
      pulse_clear();
      idle();
      repeat (500) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("midreset_busy", 32'(busy), 32'd1);
      repeat (3) @(posedge clk);
      #1;
      check("midreset_busy_held", 32'(busy), 32'd1);
      check("midreset_disp_data", 32'(disp_data), 32'd0);
      @(posedge clk);
      #3;
      rst_n      = 1'b1;
      busy_start = busy_cnt;
      wait_idle("midreset_sweep_cycles", 1024);

      rd(16'h0210, 8'h00, "midreset_0210");
      rd(16'h0400, 8'h00, "midreset_0400");
      rd(16'h05FF, 8'h00, "midreset_05FF");
      idle();
      repeat (3) idle();
      check("sb_drain", 32'(sb_q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
